nav_sequencer: RTL

- Run-time controller that walks the planned node/turn list produced by the path planner on the Maize terrain.
- Counts line-follower node detections and stops the bot at status nodes to request a status-message transmission.
- Issues turn commands to the motor block at planned turn nodes, then signals route completion.
- Sits between the planner (path table read port), the line-follower/motor block and the message transmitter.

---
 rtl/nav_pkg.sv | 27 ++
 rtl/nav_timeout_cnt.sv | 28 ++
 rtl/nav_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// Shared encodings for the navigation sequencer: motor commands (same codes as
// the planner's turn field), status-message numbers and the sequencer states.
package nav_pkg;

    localparam logic [2:0] CMD_STOP  = 3'd0;
    localparam logic [2:0] CMD_FWD   = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd5;
    localparam logic [2:0] CMD_LEFT  = 3'd6;

    localparam logic [1:0] SI_NONE = 2'd0;
    localparam logic [1:0] SI_1    = 2'd1;
    localparam logic [1:0] SI_2    = 2'd2;
    localparam logic [1:0] SI_3    = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_PLAN,
        ST_FETCH,
        ST_FOLLOW,
        ST_CHECK,
        ST_MSG,
        ST_TURN,
        ST_DONE,
        ST_ERR
    } nav_state_t;

endpackage

// File: rtl/nav_timeout_cnt.sv
// Loadable down-counter watchdog; expired is high while the count sits at zero.
// Load has priority over decrement; the count never wraps below zero.
module nav_timeout_cnt #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/nav_sequencer.sv
// Walks the planner's node/turn table: counts node crossings, stops for status
// messages, issues turns and flags route completion or turn timeout.
module nav_sequencer
    import nav_pkg::*;
#(
    parameter int MAX_STEPS    = 8,
    parameter int NODE_W       = 6,
    parameter int IDX_W        = 4,
    parameter int TURN_TIMEOUT = 3125000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              plan_valid,
    input  logic [IDX_W-1:0]  plan_len,
    output logic [IDX_W-1:0]  plan_idx,
    input  logic [NODE_W-1:0] plan_node,
    input  logic [2:0]        plan_turn,
    input  logic              node_det,
    input  logic [1:0]        status_si,
    output logic [NODE_W-1:0] cur_node,
    output logic [2:0]        cmd,
    input  logic              turn_done,
    output logic              msg_req,
    output logic [1:0]        msg_si,
    input  logic              msg_ack,
    output logic              done,
    output logic              err
);

    localparam int TW = $clog2(TURN_TIMEOUT);

    if ((2 ** IDX_W) <= MAX_STEPS) begin : g_bad_idx_w
        $error("IDX_W too narrow for MAX_STEPS");
    end

    nav_state_t        state;
    logic [NODE_W-1:0] tgt_node;
    logic [2:0]        tgt_turn;
    logic              turn_expired;

    // Watchdog is held at its full budget outside TURN and counts down inside.
    nav_timeout_cnt #(.W(TW)) u_turn_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state != ST_TURN),
        .load_val (TW'(TURN_TIMEOUT - 1)),
        .dec      (state == ST_TURN),
        .expired  (turn_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cmd      <= CMD_STOP;
            plan_idx <= '0;
            cur_node <= '0;
            msg_req  <= 1'b0;
            msg_si   <= SI_NONE;
            done     <= 1'b0;
            err      <= 1'b0;
            tgt_node <= '0;
            tgt_turn <= CMD_STOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= plan_valid ? ST_FETCH : ST_WAIT_PLAN;
                end
                ST_WAIT_PLAN: begin
                    if (plan_valid) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (plan_idx == plan_len) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        cmd   <= CMD_STOP;
                    end else begin
                        tgt_node <= plan_node;
                        tgt_turn <= plan_turn;
                        state    <= ST_FOLLOW;
                        cmd      <= CMD_FWD;
                    end
                end
                ST_FOLLOW: begin
                    if (node_det) begin
                        if (cur_node != '1) cur_node <= cur_node + 1'b1;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // status_si already reflects the freshly incremented cur_node
                    if (status_si != SI_NONE) begin
                        msg_si  <= status_si;
                        msg_req <= 1'b1;
                        cmd     <= CMD_STOP;
                        state   <= ST_MSG;
                    end else if (cur_node == tgt_node) begin
                        cmd   <= tgt_turn;
                        state <= ST_TURN;
                    end else begin
                        state <= ST_FOLLOW;
                    end
                end
                ST_MSG: begin
                    if (msg_ack) begin
                        msg_req <= 1'b0;
                        if (cur_node == tgt_node) begin
                            cmd   <= tgt_turn;
                            state <= ST_TURN;
                        end else begin
                            cmd   <= CMD_FWD;
                            state <= ST_FOLLOW;
                        end
                    end
                end
                ST_TURN: begin
                    if (turn_done) begin
                        plan_idx <= plan_idx + 1'b1;
                        cmd      <= CMD_STOP;
                        state    <= ST_FETCH;
                    end else if (turn_expired) begin
                        err   <= 1'b1;
                        cmd   <= CMD_STOP;
                        state <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        plan_idx <= '0;
                        cur_node <= '0;
                        state    <= plan_valid ? ST_FETCH : ST_WAIT_PLAN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cmd   <= CMD_STOP;
                end
            endcase
        end
    end

endmodule
